// File: rtl/com_bus_arbiter_mc.sv
// -----------------------------------------------------------------------------
// com_bus_arbiter_mc
// Common-bus arbiter for the N-core MESI cache system. Three request classes
// compete for the bus with fixed priority snoop > memory > proc. The snoop and
// proc classes are round-robin within the class. A grant is held until its
// owner drops the request. Handover to the next winner happens at that same
// edge. A hold monitor flags proc/snoop grants that stay held too long.
//
// Ports
//   clk, rst_n          clock / asynchronous active-low reset
//   Com_Bus_Req_proc    [NUM_REQ] processor-side requests (2c = DL, 2c+1 = IL)
//   Com_Bus_Req_snoop   [NUM_REQ] snoop-side requests
//   Mem_snoop_req       lower-level memory request
//   Com_Bus_Gnt_proc    [NUM_REQ] one-hot proc grant
//   Com_Bus_Gnt_snoop   [NUM_REQ] one-hot snoop grant
//   Mem_snoop_gnt       memory grant
//   Bus_busy            any grant asserted
//   Gnt_id              [ID_W] proc/snoop owner index (0 for memory/idle)
//   Hold_timeout        sticky flag: a grant was held MAX_HOLD cycles
// -----------------------------------------------------------------------------
module com_bus_arbiter_mc #(
    parameter int CORES    = 4,
    parameter int NUM_REQ  = 2 * CORES,
    parameter int ID_W     = $clog2(NUM_REQ),
    parameter int MAX_HOLD = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] Com_Bus_Req_proc,
    input  logic [NUM_REQ-1:0] Com_Bus_Req_snoop,
    input  logic               Mem_snoop_req,
    output logic [NUM_REQ-1:0] Com_Bus_Gnt_proc,
    output logic [NUM_REQ-1:0] Com_Bus_Gnt_snoop,
    output logic               Mem_snoop_gnt,
    output logic               Bus_busy,
    output logic [ID_W-1:0]    Gnt_id,
    output logic               Hold_timeout
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SNOOP = 2'd1;
    localparam logic [1:0] ST_MEM   = 2'd2;
    localparam logic [1:0] ST_PROC  = 2'd3;

    localparam int               CNT_W    = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
    localparam logic [ID_W-1:0]  LAST_IDX = ID_W'(NUM_REQ - 1);

    logic [1:0]         state_q,     state_d;
    logic [NUM_REQ-1:0] gnt_proc_q,  gnt_proc_d;
    logic [NUM_REQ-1:0] gnt_snoop_q, gnt_snoop_d;
    logic               mem_gnt_q,   mem_gnt_d;
    logic [ID_W-1:0]    gnt_id_q,    gnt_id_d;
    logic [ID_W-1:0]    ptr_proc_q,  ptr_proc_d;
    logic [ID_W-1:0]    ptr_snoop_q, ptr_snoop_d;
    logic [CNT_W-1:0]   hold_cnt_q,  hold_cnt_d;
    logic               timeout_q,   timeout_d;

    logic               owner_req;
    logic [ID_W:0]      snoop_pick, proc_pick;

    // Round-robin search starting at ptr. The loop runs from the farthest
    // offset down so the nearest requester (smallest offset) wins.
    // Result is {found, index}.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [ID_W-1:0]    ptr);
        logic [ID_W:0] res;
        int            p;
        res = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            p = int'(ptr) + i;
            if (p >= NUM_REQ) p = p - NUM_REQ;
            if (req[ID_W'(p)]) res = {1'b1, ID_W'(p)};
        end
        return res;
    endfunction

    function automatic logic [ID_W-1:0] ptr_next(input logic [ID_W-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    assign snoop_pick = rr_pick(Com_Bus_Req_snoop, ptr_snoop_q);
    assign proc_pick  = rr_pick(Com_Bus_Req_proc,  ptr_proc_q);

    always_comb begin
        owner_req = 1'b0;
        case (state_q)
            ST_SNOOP: owner_req = |(Com_Bus_Req_snoop & gnt_snoop_q);
            ST_MEM:   owner_req = Mem_snoop_req;
            ST_PROC:  owner_req = |(Com_Bus_Req_proc & gnt_proc_q);
            default:  owner_req = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        gnt_proc_d  = gnt_proc_q;
        gnt_snoop_d = gnt_snoop_q;
        mem_gnt_d   = mem_gnt_q;
        gnt_id_d    = gnt_id_q;
        ptr_proc_d  = ptr_proc_q;
        ptr_snoop_d = ptr_snoop_q;
        hold_cnt_d  = hold_cnt_q;
        timeout_d   = timeout_q;

        if (!owner_req) begin
            // Idle, or the owner released this edge. Re-arbitrate now so a
            // pending requester takes over without an idle cycle.
            state_d     = ST_IDLE;
            gnt_proc_d  = '0;
            gnt_snoop_d = '0;
            mem_gnt_d   = 1'b0;
            gnt_id_d    = '0;
            hold_cnt_d  = '0;
            if (snoop_pick[ID_W]) begin
                state_d     = ST_SNOOP;
                gnt_snoop_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << snoop_pick[ID_W-1:0];
                gnt_id_d    = snoop_pick[ID_W-1:0];
                ptr_snoop_d = ptr_next(snoop_pick[ID_W-1:0]);
            end else if (Mem_snoop_req) begin
                state_d   = ST_MEM;
                mem_gnt_d = 1'b1;
            end else if (proc_pick[ID_W]) begin
                state_d    = ST_PROC;
                gnt_proc_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << proc_pick[ID_W-1:0];
                gnt_id_d   = proc_pick[ID_W-1:0];
                ptr_proc_d = ptr_next(proc_pick[ID_W-1:0]);
            end
        end else if (state_q != ST_MEM && MAX_HOLD != 0) begin
            // Owner still holding a proc/snoop grant: count held cycles.
            // The grant is never revoked here; the timeout is only reported.
            if (hold_cnt_q != HOLD_MAX) hold_cnt_d = hold_cnt_q + 1'b1;
            if (hold_cnt_d == HOLD_MAX) timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gnt_proc_q  <= '0;
            gnt_snoop_q <= '0;
            mem_gnt_q   <= 1'b0;
            gnt_id_q    <= '0;
            ptr_proc_q  <= '0;
            ptr_snoop_q <= '0;
            hold_cnt_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_proc_q  <= gnt_proc_d;
            gnt_snoop_q <= gnt_snoop_d;
            mem_gnt_q   <= mem_gnt_d;
            gnt_id_q    <= gnt_id_d;
            ptr_proc_q  <= ptr_proc_d;
            ptr_snoop_q <= ptr_snoop_d;
            hold_cnt_q  <= hold_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign Com_Bus_Gnt_proc  = gnt_proc_q;
    assign Com_Bus_Gnt_snoop = gnt_snoop_q;
    assign Mem_snoop_gnt     = mem_gnt_q;
    assign Gnt_id            = gnt_id_q;
    assign Hold_timeout      = timeout_q;
    // Derived only from registered grants, so no request-to-busy path.
    assign Bus_busy          = (|gnt_proc_q) | (|gnt_snoop_q) | mem_gnt_q;

endmodule

// File: tb/tb_com_bus_arbiter_mc.sv
module tb_com_bus_arbiter_mc;

    localparam int NR = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NR-1:0] req_p = '0, req_s = '0;
    logic          mreq = 1'b0;

    logic [NR-1:0] gp, gs, gp4, gs4;
    logic          mg, busy, to, mg4, busy4, to4;
    logic [2:0]    id, id4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    com_bus_arbiter_mc dut (
        .clk(clk), .rst_n(rst_n),
        .Com_Bus_Req_proc(req_p), .Com_Bus_Req_snoop(req_s), .Mem_snoop_req(mreq),
        .Com_Bus_Gnt_proc(gp), .Com_Bus_Gnt_snoop(gs), .Mem_snoop_gnt(mg),
        .Bus_busy(busy), .Gnt_id(id), .Hold_timeout(to)
    );

    // Same inputs, short hold limit, used for the timeout sequence.
    com_bus_arbiter_mc #(.MAX_HOLD(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .Com_Bus_Req_proc(req_p), .Com_Bus_Req_snoop(req_s), .Mem_snoop_req(mreq),
        .Com_Bus_Gnt_proc(gp4), .Com_Bus_Gnt_snoop(gs4), .Mem_snoop_gnt(mg4),
        .Bus_busy(busy4), .Gnt_id(id4), .Hold_timeout(to4)
    );

    typedef struct {
        logic [7:0] rp, rs;
        logic       rm;
        logic [7:0] egp, egs;
        logic       emg;
        logic [2:0] eid;
    } vec_t;

    vec_t vecs[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_onehot(input string name);
        chk(name, 32'($countones({gp, gs, mg}) <= 1), 32'd1);
    endtask

    task automatic step(input logic [7:0] p, input logic [7:0] s, input logic m);
        req_p = p; req_s = s; mreq = m;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_p = '0; req_s = '0; mreq = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int owner;
        int nxt;
        // rp, rs, rm -> gnt_proc, gnt_snoop, mem_gnt, id
        vecs[0]  = '{8'h04, 8'h00, 0, 8'h04, 8'h00, 0, 3'd2};  // single proc
        vecs[1]  = '{8'h04, 8'h00, 0, 8'h04, 8'h00, 0, 3'd2};
        vecs[2]  = '{8'h04, 8'h00, 0, 8'h04, 8'h00, 0, 3'd2};
        vecs[3]  = '{8'h04, 8'h00, 0, 8'h04, 8'h00, 0, 3'd2};
        vecs[4]  = '{8'h04, 8'h00, 0, 8'h04, 8'h00, 0, 3'd2};
        vecs[5]  = '{8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 3'd0};  // release -> idle, ptr=3
        vecs[6]  = '{8'h02, 8'h00, 0, 8'h02, 8'h00, 0, 3'd1};  // proc 1 owns
        vecs[7]  = '{8'h02, 8'h10, 1, 8'h02, 8'h00, 0, 3'd1};  // no pre-emption
        vecs[8]  = '{8'h00, 8'h10, 1, 8'h00, 8'h10, 0, 3'd4};  // snoop beats mem
        vecs[9]  = '{8'h00, 8'h10, 1, 8'h00, 8'h10, 0, 3'd4};
        vecs[10] = '{8'h00, 8'h00, 1, 8'h00, 8'h00, 1, 3'd0};  // mem on snoop release
        vecs[11] = '{8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 3'd0};
        vecs[12] = '{8'h40, 8'h00, 0, 8'h40, 8'h00, 0, 3'd6};  // proc ptr -> 7
        vecs[13] = '{8'h81, 8'h00, 0, 8'h80, 8'h00, 0, 3'd7};  // handover to 7
        vecs[14] = '{8'h81, 8'h00, 0, 8'h80, 8'h00, 0, 3'd7};
        vecs[15] = '{8'h01, 8'h00, 0, 8'h01, 8'h00, 0, 3'd0};  // wrap to 0
        vecs[16] = '{8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 3'd0};
        vecs[17] = '{8'h03, 8'h00, 0, 8'h02, 8'h00, 0, 3'd1};  // ptr was 1
        vecs[18] = '{8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 3'd0};
        vecs[19] = '{8'h08, 8'h08, 0, 8'h00, 8'h08, 0, 3'd3};  // same index: snoop wins
        vecs[20] = '{8'h08, 8'h00, 0, 8'h08, 8'h00, 0, 3'd3};  // then proc 3
        vecs[21] = '{8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 3'd0};

        // Reset state
        #2;
        chk("rst_gnt_proc", 32'(gp), 32'h0);
        chk("rst_gnt_snoop", 32'(gs), 32'h0);
        chk("rst_mem_gnt", 32'(mg), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_id", 32'(id), 32'h0);
        chk("rst_timeout", 32'(to), 32'h0);
        do_reset();

        foreach (vecs[i]) begin
            step(vecs[i].rp, vecs[i].rs, vecs[i].rm);
            chk($sformatf("v%0d_gnt_proc", i), 32'(gp), 32'(vecs[i].egp));
            chk($sformatf("v%0d_gnt_snoop", i), 32'(gs), 32'(vecs[i].egs));
            chk($sformatf("v%0d_mem_gnt", i), 32'(mg), 32'(vecs[i].emg));
            chk($sformatf("v%0d_id", i), 32'(id), 32'(vecs[i].eid));
            chk($sformatf("v%0d_busy", i), 32'(busy),
                32'((vecs[i].egp != 0) || (vecs[i].egs != 0) || vecs[i].emg));
            chk($sformatf("v%0d_onehot", i), 32'($countones({gp, gs, mg}) <= 1), 32'd1);
        end
        chk("tbl_timeout", 32'(to), 32'h0);

        // Round-robin: all requesting, each owner releases after 2 held cycles.
        do_reset();
        owner = 0;
        step(8'hFF, 8'h00, 0);
        for (int n = 0; n < 9; n++) begin
            chk($sformatf("rr%0d_grant", n), 32'(gp), 32'(8'h01 << owner));
            chk($sformatf("rr%0d_id", n), 32'(id), 32'(owner));
            step(8'hFF, 8'h00, 0);
            chk($sformatf("rr%0d_hold", n), 32'(gp), 32'(8'h01 << owner));
            chk_onehot($sformatf("rr%0d_onehot", n));
            nxt = (owner + 1) % NR;
            step(8'hFF & ~(8'h01 << owner), 8'h00, 0);
            owner = nxt;
        end
        step(8'h00, 8'h00, 0);
        chk("rr_idle", 32'(busy), 32'h0);

        // Hold timeout with limit 4: proc 3 held for 6 cycles.
        do_reset();
        for (int n = 1; n <= 6; n++) begin
            step(8'h08, 8'h00, 0);
            chk($sformatf("to%0d_grant", n), 32'(gp4), 32'h08);
            chk($sformatf("to%0d_flag", n), 32'(to4), 32'(n >= 5));
        end
        step(8'h00, 8'h00, 0);
        chk("to_release", 32'(gp4), 32'h00);
        chk("to_sticky", 32'(to4), 32'h1);
        chk("to_main_clear", 32'(to), 32'h0);

        // Asynchronous reset in the middle of a held grant.
        step(8'h04, 8'h00, 0);
        chk("mid_pre_grant", 32'(gp), 32'h04);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt", 32'(gp4), 32'h0);
        chk("mid_rst_gnt_main", 32'(gp), 32'h0);
        chk("mid_rst_id", 32'(id), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_timeout", 32'(to4), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
